// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store align buffer: funct3 store sizes, byte-mask constants, FIFO entry layout.
package store_align_buffer_pkg;

    typedef enum logic [1:0] {
        F3_SB = 2'b00,
        F3_SH = 2'b01,
        F3_SW = 2'b10
    } store_size_e;

    localparam logic [3:0] MASK_SB    = 4'b0001;
    localparam logic [3:0] MASK_SH_LO = 4'b0011;
    localparam logic [3:0] MASK_SH_HI = 4'b1100;
    localparam logic [3:0] MASK_SW    = 4'b1111;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } store_entry_t;

endpackage

// File: rtl/store_align_buffer_lane_align.sv
// Combinational byte-lane alignment for SB/SH/SW: replicated write data, byte mask, misalignment flag.
module store_lane_align
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        wmask      = MASK_SW;
        misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                wmask = MASK_SB << addr_lo;
            end
            F3_SH: begin
                wdata      = {2{data[15:0]}};
                wmask      = addr_lo[1] ? MASK_SH_HI : MASK_SH_LO;
                misaligned = addr_lo[0];
            end
            // 2'b11 has no store meaning of its own and is handled as SW
            default: begin
                wdata      = data;
                wmask      = MASK_SW;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store queue: aligns SB/SH/SW requests and buffers them in a DEPTH-entry FIFO toward the dmem write port.
// Optional STORE_MISALIGN_TRAP_EN drops misaligned SH/SW and pulses o_misaligned.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [2:0]  i_st_funct3,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_data,
    output logic        o_dmem_wvalid,
    input  logic        i_dmem_wready,
    output logic [31:0] o_dmem_waddr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wmask,
    output logic        o_empty,
    output logic        o_misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    store_entry_t mem [DEPTH];
    store_entry_t head;
    store_entry_t new_entry;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic        lane_misaligned;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        unused_funct3_b2;

    assign unused_funct3_b2 = i_st_funct3[2];

    store_lane_align u_lane_align (
        .funct3     (i_st_funct3[1:0]),
        .addr_lo    (i_st_addr[1:0]),
        .data       (i_st_data),
        .wdata      (lane_wdata),
        .wmask      (lane_wmask),
        .misaligned (lane_misaligned)
    );

    assign new_entry.waddr = i_st_addr[31:2];
    assign new_entry.wdata = lane_wdata;
    assign new_entry.wmask = lane_wmask;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept = i_st_valid && !full;
    assign pop    = !empty && i_dmem_wready;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign push = accept && !lane_misaligned;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= accept && lane_misaligned;
        end
    end

    assign o_misaligned = misaligned_q;
`else
    logic unused_misaligned;

    assign unused_misaligned = lane_misaligned;
    assign push              = accept;
    assign o_misaligned      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= new_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Head is read straight out of storage, so it stays put until the pop edge.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign o_dmem_waddr  = {head.waddr, 2'b00};
    assign o_dmem_wdata  = head.wdata;
    assign o_dmem_wmask  = head.wmask;
    assign o_dmem_wvalid = !empty;
    assign o_empty       = empty;
    assign o_st_ready    = !full;

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed self-checking bench for store_align_buffer (DEPTH=2); the misaligned case follows STORE_MISALIGN_TRAP_EN.
module tb_store_align_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_st_valid;
    logic        o_st_ready;
    logic [2:0]  i_st_funct3;
    logic [31:0] i_st_addr;
    logic [31:0] i_st_data;
    logic        o_dmem_wvalid;
    logic        i_dmem_wready;
    logic [31:0] o_dmem_waddr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_wmask;
    logic        o_empty;
    logic        o_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    store_align_buffer #(.DEPTH(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_st_valid    (i_st_valid),
        .o_st_ready    (o_st_ready),
        .i_st_funct3   (i_st_funct3),
        .i_st_addr     (i_st_addr),
        .i_st_data     (i_st_data),
        .o_dmem_wvalid (o_dmem_wvalid),
        .i_dmem_wready (i_dmem_wready),
        .o_dmem_waddr  (o_dmem_waddr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_wmask  (o_dmem_wmask),
        .o_empty       (o_empty),
        .o_misaligned  (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        i_st_valid  = 1'b1;
        i_st_funct3 = f3;
        i_st_addr   = addr;
        i_st_data   = data;
    endtask

    task automatic check_head(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask);
        check_eq({tag, "_wvalid"}, {31'd0, o_dmem_wvalid}, 32'd1);
        check_eq({tag, "_waddr"}, o_dmem_waddr, addr);
        check_eq({tag, "_wdata"}, o_dmem_wdata, data);
        check_eq({tag, "_wmask"}, {28'd0, o_dmem_wmask}, {28'd0, mask});
    endtask

    initial begin
        i_rst         = 1'b1;
        i_st_valid    = 1'b0;
        i_st_funct3   = 3'b000;
        i_st_addr     = '0;
        i_st_data     = '0;
        i_dmem_wready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;

        check_eq("rst_empty", {31'd0, o_empty}, 32'd1);
        check_eq("rst_ready", {31'd0, o_st_ready}, 32'd1);
        check_eq("rst_wvalid", {31'd0, o_dmem_wvalid}, 32'd0);
        check_eq("rst_waddr", o_dmem_waddr, 32'h0);
        check_eq("rst_wdata", o_dmem_wdata, 32'h0);
        check_eq("rst_wmask", {28'd0, o_dmem_wmask}, 32'h0);
        check_eq("rst_misal", {31'd0, o_misaligned}, 32'd0);

        // 1: SB to lane 3
        i_dmem_wready = 1'b1;
        drive(3'b000, 32'h0000_0103, 32'hAABB_CC5A);
        tick();
        i_st_valid = 1'b0;
        check_head("sb", 32'h0000_0100, 32'h5A5A_5A5A, 4'b1000);
        tick();
        check_eq("sb_empty", {31'd0, o_empty}, 32'd1);
        check_eq("sb_wvalid_off", {31'd0, o_dmem_wvalid}, 32'd0);

        // 2: SH upper half, then SW (funct3 bit 2 set, must be ignored)
        drive(3'b001, 32'h0000_0202, 32'h1234_BEEF);
        tick();
        i_st_valid = 1'b0;
        check_head("sh", 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100);
        tick();
        drive(3'b110, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        i_st_valid = 1'b0;
        check_head("sw", 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
        tick();
        drive(3'b000, 32'h0000_0500, 32'h0000_0011);
        tick();
        i_st_valid = 1'b0;
        check_head("sb0", 32'h0000_0500, 32'h1111_1111, 4'b0001);
        tick();

        // 3: fill with wready low, third request must wait
        i_dmem_wready = 1'b0;
        drive(3'b010, 32'h0000_1000, 32'h0000_00A1);
        tick();
        drive(3'b010, 32'h0000_1004, 32'h0000_00B2);
        tick();
        check_eq("full_ready", {31'd0, o_st_ready}, 32'd0);
        drive(3'b010, 32'h0000_1008, 32'h0000_00C3);
        tick();
        check_eq("full_ready_held", {31'd0, o_st_ready}, 32'd0);
        check_head("full_head_stable", 32'h0000_1000, 32'h0000_00A1, 4'b1111);
        i_dmem_wready = 1'b1;
        tick();
        check_head("drain_b", 32'h0000_1004, 32'h0000_00B2, 4'b1111);
        tick();
        i_st_valid = 1'b0;
        check_head("drain_c", 32'h0000_1008, 32'h0000_00C3, 4'b1111);
        tick();
        check_eq("drain_empty", {31'd0, o_empty}, 32'd1);

        // 4: one resident entry, push+pop every cycle
        drive(3'b010, 32'h0000_2000, 32'h0000_1000);
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(3'b010, 32'h0000_2000 + 32'(i) * 4, 32'h0000_1000 + 32'(i));
            check_eq("stream_wdata", o_dmem_wdata, 32'h0000_1000 + 32'(i - 1));
            check_eq("stream_notempty", {31'd0, o_empty}, 32'd0);
            tick();
        end
        i_st_valid = 1'b0;
        check_eq("stream_last", o_dmem_wdata, 32'h0000_100A);
        check_eq("stream_last_ready", {31'd0, o_st_ready}, 32'd1);
        tick();
        check_eq("stream_empty", {31'd0, o_empty}, 32'd1);

        // 5: reset with two entries pending
        i_dmem_wready = 1'b0;
        drive(3'b010, 32'h0000_3000, 32'h0000_0001);
        tick();
        drive(3'b010, 32'h0000_3004, 32'h0000_0002);
        tick();
        i_st_valid = 1'b0;
        check_eq("pre_rst_full", {31'd0, o_st_ready}, 32'd0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_eq("rst2_empty", {31'd0, o_empty}, 32'd1);
        check_eq("rst2_wvalid", {31'd0, o_dmem_wvalid}, 32'd0);
        check_eq("rst2_ready", {31'd0, o_st_ready}, 32'd1);
        check_eq("rst2_waddr", o_dmem_waddr, 32'h0);

        // 6: misaligned SW
        i_dmem_wready = 1'b1;
        drive(3'b010, 32'h0000_0041, 32'h0BAD_F00D);
        tick();
        i_st_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        check_eq("misal_pulse", {31'd0, o_misaligned}, 32'd1);
        check_eq("misal_empty", {31'd0, o_empty}, 32'd1);
        tick();
        check_eq("misal_pulse_end", {31'd0, o_misaligned}, 32'd0);
        check_eq("misal_still_empty", {31'd0, o_empty}, 32'd1);
`else
        check_head("misal_sw", 32'h0000_0040, 32'h0BAD_F00D, 4'b1111);
        check_eq("misal_tied", {31'd0, o_misaligned}, 32'd0);
        tick();
        check_eq("misal_drained", {31'd0, o_empty}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
